// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared definitions for the ATM account access path: operation
//               encodings, arbiter state encoding, default balance width.
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    // Balance width shared with the session FSMs.
    localparam int DEFAULT_BAL_W = 20;

    // Transaction operations issued by a session FSM.
    typedef enum logic [1:0] {
        OP_WITHDRAW = 2'b00,
        OP_DEPOSIT  = 2'b01,
        OP_INQUIRY  = 2'b10,
        OP_INVALID  = 2'b11
    } op_e;

    // Arbiter transaction sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. The first unmasked request at
//               or above the pointer (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    assign eligible = req & ~mask;

    // Scan from the pointer upward, wrapping, and keep the first eligible hit.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid && eligible[cand_idx]) begin
                valid               = 1'b1;
                winner_idx          = cand_idx;
                winner_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/account_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : account_access_arbiter
// Description : Round-robin sharing of a single-port account RAM between ATM
//               session FSMs; each transaction is an atomic read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module account_access_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BAL_W   = DEFAULT_BAL_W,
    parameter int ADDR_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_acct,
    input  logic [BAL_W*NUM_REQ-1:0]  req_value,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [BAL_W-1:0]          rsp_balance,
    output logic                      rsp_error,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [BAL_W-1:0]          mem_wdata,
    input  logic [BAL_W-1:0]          mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state;
    arb_state_e         state_next;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] owner_oh;
    op_e                op_lat;
    logic [ADDR_W-1:0]  acct_lat;
    logic [BAL_W-1:0]   value_lat;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    logic [BAL_W:0]     dep_sum;
    logic [BAL_W-1:0]   exec_result;
    logic               exec_error;
    logic               exec_write;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .mask       (mask),
        .ptr        (ptr),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .valid      (win_valid)
    );

    // Transaction result from the old balance; the extra sum bit catches
    // deposit overflow.
    always_comb begin
        dep_sum     = {1'b0, mem_rdata} + {1'b0, value_lat};
        exec_result = mem_rdata;
        exec_error  = 1'b0;
        exec_write  = 1'b0;
        case (op_lat)
            OP_WITHDRAW: begin
                if (value_lat > mem_rdata) begin
                    exec_error = 1'b1;
                end else begin
                    exec_result = mem_rdata - value_lat;
                    exec_write  = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (dep_sum[BAL_W]) begin
                    exec_error = 1'b1;
                end else begin
                    exec_result = dep_sum[BAL_W-1:0];
                    exec_write  = 1'b1;
                end
            end
            OP_INQUIRY: begin
                exec_result = mem_rdata;
            end
            default: begin
                exec_error = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus RAM/handshake outputs decoded from state and latches.
    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                gnt        = owner_oh;
                mem_en     = 1'b1;
                mem_addr   = acct_lat;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                gnt = owner_oh;
                if (exec_write) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = acct_lat;
                    mem_wdata = exec_result;
                end
                state_next = ST_DONE;
            end
            ST_DONE: begin
                gnt        = owner_oh;
                done       = owner_oh;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Winner capture, pointer advance, post-service mask and response regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            mask        <= '0;
            owner_oh    <= '0;
            op_lat      <= OP_WITHDRAW;
            acct_lat    <= '0;
            value_lat   <= '0;
            rsp_balance <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The mask only shields the first IDLE cycle after DONE.
                    mask <= '0;
                    if (win_valid) begin
                        owner_oh  <= win_oh;
                        op_lat    <= op_e'(req_op[2*win_idx +: 2]);
                        acct_lat  <= req_acct[ADDR_W*win_idx +: ADDR_W];
                        value_lat <= req_value[BAL_W*win_idx +: BAL_W];
                        if (win_idx == IDX_W'(NUM_REQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= win_idx + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_balance <= exec_result;
                    rsp_error   <= exec_error;
                end
                ST_DONE: begin
                    mask <= owner_oh;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_account_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_account_access_arbiter
// Description : Self-checking bench for account_access_arbiter with a
//               behavioural RAM and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_account_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BAL_W   = 20;
    localparam int ADDR_W  = 8;
    localparam int MAXB    = (1 << BAL_W) - 1;

    localparam logic [1:0] C_WD  = 2'b00;
    localparam logic [1:0] C_DEP = 2'b01;
    localparam logic [1:0] C_INQ = 2'b10;
    localparam logic [1:0] C_BAD = 2'b11;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [2*NUM_REQ-1:0]      req_op = '0;
    logic [ADDR_W*NUM_REQ-1:0] req_acct = '0;
    logic [BAL_W*NUM_REQ-1:0]  req_value = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [BAL_W-1:0]          rsp_balance;
    logic                      rsp_error;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [BAL_W-1:0]          mem_wdata;
    logic [BAL_W-1:0]          mem_rdata = '0;

    logic [BAL_W-1:0]  ram [256];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [BAL_W-1:0]  pl_data = '0;
    int                wr_cnt = 0;

    int total = 0;
    int bad   = 0;
    int model_bal [4];

    account_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BAL_W   (BAL_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .req_acct    (req_acct),
        .req_value   (req_value),
        .gnt         (gnt),
        .done        (done),
        .rsp_balance (rsp_balance),
        .rsp_error   (rsp_error),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with a one-cycle read and a preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    function automatic int onehot_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Round-robin rule: first pending index at or above p, wrapping.
    function automatic int rr_pick(input logic [3:0] pend, input int p);
        for (int k = 0; k < 4; k++) if (pend[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Account arithmetic on plain integers.
    function automatic void model_txn(input int op, input int b, input int v,
                                      output int nb, output bit err);
        nb  = b;
        err = 1'b0;
        case (op)
            0: if (v > b) err = 1'b1; else nb = b - v;
            1: if (b + v > MAXB) err = 1'b1; else nb = b + v;
            2: nb = b;
            default: err = 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [19:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [19:0] v);
        req_op[2*i +: 2]      = op;
        req_acct[8*i +: 8]    = a;
        req_value[20*i +: 20] = v;
        req[i]                = 1'b1;
    endtask

    // Issue one transaction alone and wait (bounded) for its done pulse.
    task automatic run_one(input int i, input logic [1:0] op, input logic [7:0] a,
                           input logic [19:0] v, output logic [3:0] dv,
                           output logic [19:0] bal, output logic err,
                           output int writes, output int lat, output bit ok);
        int wc;
        wc  = wr_cnt;
        ok  = 1'b0;
        lat = 0;
        dv  = '0;
        bal = '0;
        err = 1'b0;
        drive(i, op, a, v);
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            lat++;
            if (done != 0) begin
                ok  = 1'b1;
                dv  = done;
                bal = rsp_balance;
                err = rsp_error;
            end
        end
        req[i] = 1'b0;
        writes = wr_cnt - wc;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
        total++; if (done !== 4'b0) begin bad++; $display("FAIL rst_done got=%b want=0000", done); end
        total++; if (rsp_balance !== 20'd0) begin bad++; $display("FAIL rst_bal got=%0d want=0", rsp_balance); end
        total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", rsp_error); end
        total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_mem_ctl got=%b want=00", {mem_en, mem_we}); end
        total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", mem_addr); end
        total++; if (mem_wdata !== 20'd0) begin bad++; $display("FAIL rst_wdata got=%0d want=0", mem_wdata); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({mem_en, gnt} !== 5'b0) begin bad++; $display("FAIL idle_quiet got=%b want=0", {mem_en, gnt}); end
    endtask

    task automatic test_single_withdraw();
        int wc;
        do_reset();
        preload(8'd5, 20'd1000);
        wc = wr_cnt;
        drive(0, C_WD, 8'd5, 20'd300);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL t1_gnt got=%b want=0001", gnt); end
        total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'd5}) begin bad++; $display("FAIL t1_read got=%b/%b/%0d want=1/0/5", mem_en, mem_we, mem_addr); end
        total++; if (done !== 4'b0) begin bad++; $display("FAIL t1_early_done got=%b want=0000", done); end
        @(negedge clk);
        total++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 8'd5}) begin bad++; $display("FAIL t2_write got=%b/%b/%0d want=1/1/5", mem_en, mem_we, mem_addr); end
        total++; if (mem_wdata !== 20'd700) begin bad++; $display("FAIL t2_wdata got=%0d want=700", mem_wdata); end
        @(negedge clk);
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL t3_done got=%b want=0001", done); end
        total++; if (rsp_balance !== 20'd700 || rsp_error !== 1'b0) begin bad++; $display("FAIL t3_rsp got=%0d/%b want=700/0", rsp_balance, rsp_error); end
        total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL t3_mem_quiet got=%b want=00", {mem_en, mem_we}); end
        req[0] = 1'b0;
        @(negedge clk);
        total++; if ({gnt, done} !== 8'b0) begin bad++; $display("FAIL t4_clear got=%b want=0", {gnt, done}); end
        total++; if (ram[5] !== 20'd700 || wr_cnt - wc !== 1) begin bad++; $display("FAIL t1_ram got=%0d/%0d want=700/1", ram[5], wr_cnt - wc); end
        @(negedge clk);
    endtask

    task automatic test_limits();
        logic [3:0] dv; logic [19:0] bal; logic err; int wr; int lat; bit ok;
        preload(8'd5, 20'd1000);
        run_one(0, C_WD, 8'd5, 20'd1001, dv, bal, err, wr, lat, ok);
        total++; if (!ok || dv !== 4'b0001 || lat != 3) begin bad++; $display("FAIL wd_over_done got=%b lat=%0d ok=%0d want=0001 lat=3", dv, lat, ok); end
        total++; if (bal !== 20'd1000 || err !== 1'b1 || wr != 0) begin bad++; $display("FAIL wd_over got=%0d/%b/w%0d want=1000/1/w0", bal, err, wr); end
        run_one(0, C_WD, 8'd5, 20'd1000, dv, bal, err, wr, lat, ok);
        total++; if (!ok || bal !== 20'd0 || err !== 1'b0 || wr != 1) begin bad++; $display("FAIL wd_exact got=%0d/%b/w%0d want=0/0/w1", bal, err, wr); end
        total++; if (ram[5] !== 20'd0) begin bad++; $display("FAIL wd_exact_ram got=%0d want=0", ram[5]); end
        preload(8'd7, 20'(MAXB));
        run_one(1, C_DEP, 8'd7, 20'd2, dv, bal, err, wr, lat, ok);
        total++; if (!ok || dv !== 4'b0010) begin bad++; $display("FAIL dep_ovf_done got=%b want=0010", dv); end
        total++; if (bal !== 20'(MAXB) || err !== 1'b1 || wr != 0) begin bad++; $display("FAIL dep_ovf got=%0d/%b/w%0d want=%0d/1/w0", bal, err, wr, MAXB); end
        preload(8'd8, 20'd10);
        run_one(2, C_DEP, 8'd8, 20'd5, dv, bal, err, wr, lat, ok);
        total++; if (!ok || bal !== 20'd15 || err !== 1'b0 || wr != 1 || ram[8] !== 20'd15) begin bad++; $display("FAIL dep_ok got=%0d/%b/w%0d ram=%0d want=15/0/w1 ram=15", bal, err, wr, ram[8]); end
        preload(8'd9, 20'd1234);
        run_one(3, C_BAD, 8'd9, 20'd7, dv, bal, err, wr, lat, ok);
        total++; if (!ok || dv !== 4'b1000 || bal !== 20'd1234 || err !== 1'b1 || wr != 0) begin bad++; $display("FAIL op11 got=%b %0d/%b/w%0d want=1000 1234/1/w0", dv, bal, err, wr); end
        run_one(0, C_INQ, 8'd9, 20'd99, dv, bal, err, wr, lat, ok);
        total++; if (!ok || bal !== 20'd1234 || err !== 1'b0 || wr != 0) begin bad++; $display("FAIL inquiry got=%0d/%b/w%0d want=1234/0/w0", bal, err, wr); end
    endtask

    task automatic test_rr_order();
        int order[$]; logic [3:0] prev_gnt; logic [3:0] rer; int got; int mptr; int last; int exp;
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, C_INQ, 8'(8'h20 + i), 20'd0);
        prev_gnt = '0;
        rer      = '0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (rer[i]) begin req[i] = 1'b1; rer[i] = 1'b0; end
            if (gnt != 0 && prev_gnt == 0) order.push_back(onehot_idx(gnt));
            prev_gnt = gnt;
            if (done != 0) begin got = onehot_idx(done); req[got] = 1'b0; rer[got] = 1'b1; end
        end
        req = '0;
        total++; if (order.size() != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", order.size()); end
        mptr = 0;
        last = -1;
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            exp  = rr_pick(4'b1111 & ~((last >= 0) ? (4'b0001 << last) : 4'b0000), mptr);
            total++; if (order[k] != exp) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", k, order[k], exp); end
            if (k > 0) begin
                total++; if (order[k] == order[k-1]) begin bad++; $display("FAIL rr_repeat[%0d] got=%0d want!=%0d", k, order[k], order[k-1]); end
            end
            mptr = (exp + 1) % 4;
            last = exp;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq_d[$]; logic [19:0] seq_b[$]; int seq_t[$];
        do_reset();
        preload(8'd9, 20'd50);
        drive(0, C_DEP, 8'd9, 20'd100);
        drive(2, C_DEP, 8'd9, 20'd100);
        for (int c = 0; c < 20 && seq_d.size() < 2; c++) begin
            @(negedge clk);
            if (done != 0) begin
                seq_d.push_back(done);
                seq_b.push_back(rsp_balance);
                seq_t.push_back(c);
                req[onehot_idx(done)] = 1'b0;
            end
        end
        req = '0;
        total++; if (seq_d.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", seq_d.size()); end
        if (seq_d.size() == 2) begin
            total++; if (seq_d[0] !== 4'b0001 || seq_b[0] !== 20'd150) begin bad++; $display("FAIL b2b_first got=%b/%0d want=0001/150", seq_d[0], seq_b[0]); end
            total++; if (seq_d[1] !== 4'b0100 || seq_b[1] !== 20'd250) begin bad++; $display("FAIL b2b_second got=%b/%0d want=0100/250", seq_d[1], seq_b[1]); end
            total++; if (seq_t[1] - seq_t[0] != 4) begin bad++; $display("FAIL b2b_gap got=%0d want=4", seq_t[1] - seq_t[0]); end
        end
        @(negedge clk);
        total++; if (ram[9] !== 20'd250) begin bad++; $display("FAIL b2b_ram got=%0d want=250", ram[9]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] dv; logic [19:0] bal; logic err; int wr; int lat; bit ok; int wc; int seen;
        do_reset();
        preload(8'd3, 20'd500);
        run_one(1, C_INQ, 8'd3, 20'd0, dv, bal, err, wr, lat, ok);
        wc = wr_cnt;
        drive(0, C_WD, 8'd3, 20'd100);
        repeat (2) @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_exec_we got=%b want=1", mem_we); end
        #1 rst = 1'b0;
        #1;
        total++; if ({gnt, done, rsp_error, mem_en, mem_we} !== 11'b0) begin bad++; $display("FAIL mid_ctl got=%b want=0", {gnt, done, rsp_error, mem_en, mem_we}); end
        total++; if (rsp_balance !== 20'd0 || mem_addr !== 8'd0 || mem_wdata !== 20'd0) begin bad++; $display("FAIL mid_data got=%0d/%0d/%0d want=0/0/0", rsp_balance, mem_addr, mem_wdata); end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != 0) seen++;
        end
        req = '0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != 0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", seen); end
        total++; if (ram[3] !== 20'd500 || wr_cnt != wc) begin bad++; $display("FAIL mid_ram got=%0d/w%0d want=500/w0", ram[3], wr_cnt - wc); end
        run_one(0, C_INQ, 8'd3, 20'd0, dv, bal, err, wr, lat, ok);
        total++; if (!ok || bal !== 20'd500 || err !== 1'b0) begin bad++; $display("FAIL mid_inquiry got=%0d/%b want=500/0", bal, err); end
    endtask

    task automatic test_random();
        int t_op[4]; int t_k[4]; int t_val[4]; logic [3:0] pend; int mptr; int w; int got;
        int nb; bit merr; logic [3:0] exp_oh; int b;
        do_reset();
        mptr = 0;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 2))
                0: b = int'($urandom_range(0, 100));
                1: b = MAXB - int'($urandom_range(0, 50));
                default: b = int'($urandom & 32'hFFFFF);
            endcase
            model_bal[k] = b;
            preload(8'(8'h40 + k), 20'(b));
        end
        for (int r = 0; r < 30; r++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    t_op[i] = int'($urandom_range(0, 3));
                    t_k[i]  = int'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: t_val[i] = int'($urandom_range(0, 2000));
                        1: t_val[i] = int'($urandom & 32'hFFFFF);
                        2: t_val[i] = model_bal[t_k[i]];
                        default: t_val[i] = int'($urandom_range(0, 60));
                    endcase
                    drive(i, 2'(t_op[i]), 8'(8'h40 + t_k[i]), 20'(t_val[i]));
                end
            end
            for (int c = 0; c < 40 && pend != 0; c++) begin
                @(negedge clk);
                if (done != 0) begin
                    got    = onehot_idx(done);
                    w      = rr_pick(pend, mptr);
                    exp_oh = 4'b0001 << w;
                    total++; if (done !== exp_oh) begin bad++; $display("FAIL rnd_winner r%0d got=%b want=%b", r, done, exp_oh); end
                    model_txn(t_op[w], model_bal[t_k[w]], t_val[w], nb, merr);
                    model_bal[t_k[w]] = nb;
                    total++; if (rsp_balance !== 20'(nb) || rsp_error !== merr) begin bad++; $display("FAIL rnd_rsp r%0d got=%0d/%b want=%0d/%b", r, rsp_balance, rsp_error, nb, merr); end
                    mptr      = (w + 1) % 4;
                    req[got]  = 1'b0;
                    pend[got] = 1'b0;
                end
            end
            total++; if (pend != 0) begin bad++; $display("FAIL rnd_timeout r%0d got=%b want=0000", r, pend); end
            req = '0;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                total++; if (ram[8'h40 + k] !== 20'(model_bal[k])) begin bad++; $display("FAIL rnd_ram r%0d acct%0d got=%0d want=%0d", r, k, ram[8'h40 + k], model_bal[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_withdraw();
        test_limits();
        test_rr_order();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/account_access_arbiter.md
# account_access_arbiter

Shares one single-port account-balance RAM among `NUM_REQ` ATM session FSMs. Each session FSM issues withdraw, deposit or inquiry transactions against an account number. This block arbitrates round-robin and runs each transaction as an atomic read-modify-write. It returns the resulting balance and an error flag to the winning requester. It sits between the per-terminal session FSMs and the account RAM.

## Interface
- `NUM_REQ`, 4: number of session FSMs (requesters), ≥2
- `BAL_W`, 20: balance and value width
- `ADDR_W`, 8: account-number width (RAM address)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester transaction request, level, held until `done`
- `req_op`  in  2*NUM_REQ  per-requester op: 00 withdraw, 01 deposit, 10 inquiry, 11 invalid
- `req_acct`  in  ADDR_W*NUM_REQ  per-requester account number
- `req_value`  in  BAL_W*NUM_REQ  per-requester amount (ignored for inquiry)
- `gnt`  out  NUM_REQ  one-hot; the transaction owner, high from READ through DONE
- `done`  out  NUM_REQ  one-hot, one-cycle pulse in DONE
- `rsp_balance`  out  BAL_W  resulting balance, valid while `done` is high, held until the next DONE
- `rsp_error`  out  1  transaction rejected, valid with `done`
- `mem_en`  out  1  RAM access enable
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  BAL_W  RAM write data
- `mem_rdata`  in  BAL_W  RAM read data, valid the cycle after a read-enable cycle

## Operation
- States: IDLE, READ, EXEC, DONE. Reset enters IDLE.
- **IDLE**
  - If any unmasked `req` is high, pick the winner round-robin.
  - Latch the winner's op, account and value. Set `gnt`. Go to READ.
  - Advance the round-robin pointer to winner+1 (mod `NUM_REQ`).
- **READ**
  - `mem_en`=1, `mem_we`=0, `mem_addr`=latched account. Go to EXEC.
- **EXEC**
  - `mem_rdata` holds the old balance B. Compute the result:
    - Withdraw: if value > B, error and no write. Otherwise new balance B−value and write. value==B is legal and leaves 0.
    - Deposit: compute the sum at BAL_W+1 bits. If the carry is set, error and no write. Otherwise write B+value.
    - Inquiry: no write, no error.
    - Op 11: error, no write.
  - A write asserts `mem_en`=`mem_we`=1 with the same `mem_addr` and `mem_wdata`=new balance.
  - Register `rsp_balance` (new balance on success, B on error or inquiry) and `rsp_error`. Go to DONE.
- **DONE**
  - `done[winner]`=1, `gnt` still set. Go to IDLE and clear `gnt`.
- Masking: the requester just served is excluded from arbitration in the first IDLE cycle after DONE. This gives it one cycle to drop `req`.
- Deasserting `req` mid-transaction is ignored: the transaction completes and `done` still pulses. Input changes after the IDLE latch do not affect the transaction.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from state and latched registers only. They are 0 in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE, pointer 0, mask clear.
  - `gnt`, `done`, `rsp_error` = 0; `rsp_balance` = 0.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
- Request seen high in IDLE cycle T:
  - `gnt` from T+1.
  - RAM read in T+1.
  - Write (if any) in T+2.
  - `done` in T+3.
  - Earliest next grant at T+4, i.e. 4 cycles per transaction.
- A request arriving while a transaction is in flight waits. It is evaluated in the next IDLE cycle.
- Simultaneous requests: the lowest index at or above the pointer (wrapping) wins.
- Pointer wrap: after the winner is `NUM_REQ`−1, the pointer returns to 0.
- Reset mid-operation returns to IDLE immediately and drops every output to its reset value.
  - Reset asserted in READ or EXEC (before the EXEC→DONE edge): no `done`, and the RAM write is abandoned or not issued.
  - Reset asserted in DONE: the write has already completed.
- Reset does not touch RAM contents.

## Structure
- Shared package `atm_pkg`:
  - op encodings (`OP_WITHDRAW`, `OP_DEPOSIT`, `OP_INQUIRY`, `OP_INVALID`)
  - arbiter state encoding
  - default `BAL_W` (20), shared with the session FSM
- Sub-module `rr_arbiter`:
  - inputs: request vector, mask, pointer
  - outputs: one-hot winner and winner index
  - purely combinational
  - instantiated once

## Test plan
- Single requester 0, withdraw 300 from account 5 holding 1000 → `gnt`[0] T+1, RAM write 700 at T+2, `done`[0] T+3, `rsp_balance`=700, `rsp_error`=0.
- Withdraw 1001 from balance 1000 → no `mem_we` pulse, `rsp_error`=1, `rsp_balance`=1000. Withdraw 1000 → balance 0, no error.
- Deposit 2 into balance 2^20−1 → carry set, `rsp_error`=1, no write. Deposit 5 into 10 → 15 written. Op 11 → error, no write.
- `req`=1111 held continuously, each requester dropping `req` the cycle after its `done` and re-raising it → grant order 0,1,2,3,0; served requester never re-granted back-to-back.
- Requesters 0 and 2 deposit 100 each to the same account (balance 50) simultaneously → serialized, final RAM value 250, `rsp_balance` 150 then 250.
- Reset asserted during EXEC of a withdraw → all outputs 0 next cycle, no `done`. After release, a new inquiry returns the pre-existing RAM value.
